// File: rtl/sdrc_responder.sv
// rtl/sdrc_responder.sv - SDRC user command interface responder with word memory and sticky protocol checker
`timescale 1ns/1ps
module sdrc_responder #(
    parameter int MemAddressBitWidth = 12,
    parameter int ColumnBitWidth     = 8,
    parameter int InitCycles         = 16,
    parameter int RefreshCycles      = 4,
    parameter int ReadLatency        = 1,
    parameter int WriteRecovery      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        I_sdrc_cmd_en,
    input  logic [2:0]  I_sdrc_cmd,
    input  logic        I_sdrc_precharge_ctrl,
    input  logic        I_sdram_power_down,
    input  logic        I_sdram_selfrefresh,
    input  logic [20:0] I_sdrc_addr,
    input  logic [3:0]  I_sdrc_dqm,
    input  logic [31:0] I_sdrc_data,
    input  logic [7:0]  I_sdrc_data_len,
    output logic [31:0] O_sdrc_data,
    output logic        O_sdrc_init_done,
    output logic        O_sdrc_cmd_ack,
    output logic        protocol_error
);

    localparam int AW = MemAddressBitWidth;
    localparam int RW = 21 - ColumnBitWidth;

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_REFRESH, S_WRITE, S_READ, S_RECOVER
    } state_t;

    state_t          state, state_nxt;
    logic [15:0]     cnt;
    logic [7:0]      len_q;
    logic [AW-1:0]   ptr;
    logic [RW-1:0]   open_row;
    logic            row_open;
    logic            precharge_q;
    logic            refresh_pending;
    logic [31:0]     mem [0:(1<<AW)-1];

    logic is_refresh, is_activate, is_write, is_read, is_nop;
    logic [RW-1:0] cmd_row;
    logic [31:0]   col_end;
    logic          crossing;
    logic          init_last, refresh_last, write_last, read_last;
    logic [15:0]   rd_lat;

    assign is_refresh  = (I_sdrc_cmd == 3'b001);
    assign is_activate = (I_sdrc_cmd == 3'b011);
    assign is_write    = (I_sdrc_cmd == 3'b100);
    assign is_read     = (I_sdrc_cmd == 3'b101);
    assign is_nop      = (I_sdrc_cmd == 3'b111);
    assign cmd_row     = I_sdrc_addr[20:ColumnBitWidth];
    assign col_end     = 32'(I_sdrc_addr[ColumnBitWidth-1:0]) + 32'(I_sdrc_data_len);
    assign crossing    = (col_end > 32'((1 << ColumnBitWidth) - 1));

    assign rd_lat       = 16'(ReadLatency - 1);
    assign init_last    = (cnt == 16'(InitCycles - 1));
    assign refresh_last = (cnt == 16'(RefreshCycles - 1));
    assign write_last   = ((cnt + 16'd1) == 16'(len_q));
    assign read_last    = (cnt == (16'(len_q) + rd_lat));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_INIT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT: if (init_last)
                state_nxt = (refresh_pending || (I_sdrc_cmd_en && is_refresh)) ? S_REFRESH : S_IDLE;
            S_IDLE: if (I_sdrc_cmd_en) begin
                if (is_refresh)    state_nxt = S_REFRESH;
                else if (is_write) state_nxt = (I_sdrc_data_len == 8'd0) ? S_RECOVER : S_WRITE;
                else if (is_read)  state_nxt = S_READ;
            end
            S_REFRESH: if (refresh_last)                      state_nxt = S_IDLE;
            S_WRITE:   if (write_last)                        state_nxt = S_RECOVER;
            S_READ:    if (read_last)                         state_nxt = S_IDLE;
            S_RECOVER: if (cnt == 16'(WriteRecovery - 1))     state_nxt = S_IDLE;
            default:                                          state_nxt = S_INIT;
        endcase
    end

    logic          accept, ack_nxt, err_set, mem_we, rd_en, burst_end, close_row;
    logic [AW-1:0] mem_idx;

    always_comb begin
        accept    = (state == S_IDLE) && I_sdrc_cmd_en;
        ack_nxt   = (accept && (is_activate || is_write || is_read)) ||
                    ((state == S_REFRESH) && refresh_last);
        err_set   = I_sdram_power_down || I_sdram_selfrefresh;
        case (state)
            S_INIT: if (I_sdrc_cmd_en && !is_refresh && !is_nop) err_set = 1'b1;
            S_IDLE: if (I_sdrc_cmd_en) begin
                if ((is_refresh || is_activate) && row_open) err_set = 1'b1;
                if ((is_write || is_read) && (!row_open || cmd_row != open_row || crossing))
                    err_set = 1'b1;
                if (!(is_refresh || is_activate || is_write || is_read || is_nop))
                    err_set = 1'b1;
            end
            default: if (I_sdrc_cmd_en) err_set = 1'b1;
        endcase
        mem_we    = (accept && is_write) || (state == S_WRITE);
        mem_idx   = (state == S_IDLE) ? I_sdrc_addr[AW-1:0] : ptr;
        rd_en     = (state == S_READ) && (cnt >= rd_lat);
        burst_end = (accept && is_write && I_sdrc_data_len == 8'd0) ||
                    ((state == S_WRITE) && write_last) ||
                    ((state == S_READ) && read_last);
        // A zero-length write ends on its accept edge, before precharge_q is loaded
        close_row = burst_end && ((state == S_IDLE) ? I_sdrc_precharge_ctrl : precharge_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt              <= 16'd0;
            len_q            <= 8'd0;
            ptr              <= '0;
            open_row         <= '0;
            row_open         <= 1'b0;
            precharge_q      <= 1'b0;
            refresh_pending  <= 1'b0;
            O_sdrc_data      <= 32'd0;
            O_sdrc_init_done <= 1'b0;
            O_sdrc_cmd_ack   <= 1'b0;
            protocol_error   <= 1'b0;
        end else begin
            O_sdrc_cmd_ack <= ack_nxt;
            if (err_set) protocol_error <= 1'b1;
            cnt <= (state != state_nxt) ? 16'd0 : cnt + 16'd1;
            if (accept && (is_write || is_read)) begin
                len_q       <= I_sdrc_data_len;
                precharge_q <= I_sdrc_precharge_ctrl;
                ptr         <= is_write ? I_sdrc_addr[AW-1:0] + AW'(1) : I_sdrc_addr[AW-1:0];
            end
            if (state == S_WRITE) ptr <= ptr + AW'(1);
            if (rd_en) begin
                O_sdrc_data <= mem[ptr];
                ptr         <= ptr + AW'(1);
            end
            if (state == S_INIT && I_sdrc_cmd_en && is_refresh) refresh_pending <= 1'b1;
            if (state == S_INIT && init_last) begin
                O_sdrc_init_done <= 1'b1;
                refresh_pending  <= 1'b0;
            end
            if (accept && is_activate) begin
                row_open <= 1'b1;
                open_row <= cmd_row;
            end
            if (close_row) row_open <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (!I_sdrc_dqm[b]) mem[mem_idx][8*b +: 8] <= I_sdrc_data[8*b +: 8];
            end
        end
    end

endmodule
